// File: rtl/alu_core_seq_if.sv
// Operand/command bus between the ALU verification driver (master) and the
// sequential ALU responder (slave).
interface alu_core_seq_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         ce;
    logic         mode;
    logic [M-1:0] cmd;
    logic [1:0]   inp_valid;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic         cin;
    logic [N+1:0] res;
    logic         cout;
    logic         oflow;
    logic         g;
    logic         l;
    logic         e;
    logic         err;

    modport master (
        output ce, mode, cmd, inp_valid, opa, opb, cin,
        input  res, cout, oflow, g, l, e, err
    );

    modport slave (
        input  ce, mode, cmd, inp_valid, opa, opb, cin,
        output res, cout, oflow, g, l, e, err
    );
endinterface

// File: rtl/alu_core_seq.sv
// Sequential ALU responder: gathers split operands, executes arithmetic/logical
// commands with registered results. Define ALU_SIGNED_EN to add SADD/SSUB (cmd 11/12).
module alu_core_seq #(
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_core_seq_if.slave    bus
);
    localparam int SW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT);
`ifdef ALU_SIGNED_EN
    localparam logic [3:0] MAX_ARITH = 4'd12;
`else
    localparam logic [3:0] MAX_ARITH = 4'd10;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_MUL = 2'd2} state_t;

    typedef struct packed {
        logic [N+1:0] res;
        logic         cout;
        logic         oflow;
        logic         g;
        logic         l;
        logic         e;
        logic         err;
    } result_t;

    function automatic logic cmd_ok(input logic md, input logic [M-1:0] c);
        return md ? (c <= MAX_ARITH) : (c <= 4'd13);
    endfunction

    // {need_b, need_a}: which operands a command consumes
    function automatic logic [1:0] need_ops(input logic md, input logic [M-1:0] c);
        logic [1:0] n;
        n = 2'b11;
        if (md) begin
            case (c)
                4'd4, 4'd5: n = 2'b01;
                4'd6, 4'd7: n = 2'b10;
                default:    n = 2'b11;
            endcase
        end else begin
            case (c)
                4'd6, 4'd8, 4'd9:   n = 2'b01;
                4'd7, 4'd10, 4'd11: n = 2'b10;
                default:            n = 2'b11;
            endcase
        end
        return n;
    endfunction

    function automatic logic is_mul(input logic md, input logic [M-1:0] c);
        return md && ((c == 4'd9) || (c == 4'd10));
    endfunction

    function automatic result_t exec_op(input logic md, input logic [M-1:0] c,
                                        input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic ci);
        result_t        r;
        logic [N:0]     ext;
        logic [N-1:0]   lg;
        logic [2*N-1:0] dbl;
        r   = '0;
        ext = '0;
        lg  = '0;
        dbl = '0;
        if (md) begin
            case (c)
                4'd0: begin ext = {1'b0, a} + {1'b0, b}; r.res = {1'b0, ext}; r.cout = ext[N]; end
                4'd1: begin ext = {1'b0, a} - {1'b0, b}; r.res = {1'b0, ext}; r.oflow = ext[N]; end
                4'd2: begin
                    ext = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
                    r.res = {1'b0, ext}; r.cout = ext[N];
                end
                4'd3: begin
                    // N+1-bit difference is negative exactly when a borrow occurs
                    ext = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, ci};
                    r.res = {1'b0, ext}; r.oflow = ext[N];
                end
                4'd4: begin lg = a + {{(N-1){1'b0}}, 1'b1}; r.res = {2'b00, lg}; r.oflow = &a;  end
                4'd5: begin lg = a - {{(N-1){1'b0}}, 1'b1}; r.res = {2'b00, lg}; r.oflow = ~|a; end
                4'd6: begin lg = b + {{(N-1){1'b0}}, 1'b1}; r.res = {2'b00, lg}; r.oflow = &b;  end
                4'd7: begin lg = b - {{(N-1){1'b0}}, 1'b1}; r.res = {2'b00, lg}; r.oflow = ~|b; end
                4'd8: begin r.g = (a > b); r.l = (a < b); r.e = (a == b); end
`ifdef ALU_SIGNED_EN
                4'd11: begin
                    ext = {a[N-1], a} + {b[N-1], b};
                    r.res = {ext[N], ext}; r.oflow = ext[N] ^ ext[N-1];
                    r.g = ($signed(a) > $signed(b)); r.l = ($signed(a) < $signed(b)); r.e = (a == b);
                end
                4'd12: begin
                    ext = {a[N-1], a} - {b[N-1], b};
                    r.res = {ext[N], ext}; r.oflow = ext[N] ^ ext[N-1];
                    r.g = ($signed(a) > $signed(b)); r.l = ($signed(a) < $signed(b)); r.e = (a == b);
                end
`endif
                default: r.err = 1'b1;
            endcase
        end else begin
            case (c)
                4'd0:  lg = a & b;
                4'd1:  lg = ~(a & b);
                4'd2:  lg = a | b;
                4'd3:  lg = ~(a | b);
                4'd4:  lg = a ^ b;
                4'd5:  lg = ~(a ^ b);
                4'd6:  lg = ~a;
                4'd7:  lg = ~b;
                4'd8:  lg = a >> 1;
                4'd9:  lg = a << 1;
                4'd10: lg = b >> 1;
                4'd11: lg = b << 1;
                4'd12: begin dbl = {a, a} << b[SW-1:0]; lg = dbl[2*N-1:N]; r.err = |(b >> SW); end
                4'd13: begin dbl = {a, a} >> b[SW-1:0]; lg = dbl[N-1:0];   r.err = |(b >> SW); end
                default: r.err = 1'b1;
            endcase
            r.res = {2'b00, lg};
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [1:0]     missing_q, missing_d;
    logic [N-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [M-1:0]   cmd_q, cmd_d;
    logic           mode_q, mode_d, cin_q, cin_d;
    logic [N:0]     mul_x_q, mul_x_d, mul_y_q, mul_y_d;
    result_t        out_q, out_d;

    logic           go_s;
    logic           sel_mode_s, sel_cin_s;
    logic [M-1:0]   sel_cmd_s;
    logic [N-1:0]   sel_a_s, sel_b_s;
    logic [1:0]     need_s;
    logic [2*N+1:0] prod_s;

    // Next-state, operand gathering and result selection
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        missing_d  = missing_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cmd_d      = cmd_q;
        mode_d     = mode_q;
        cin_d      = cin_q;
        mul_x_d    = mul_x_q;
        mul_y_d    = mul_y_q;
        out_d      = out_q;
        go_s       = 1'b0;
        sel_mode_s = bus.mode;
        sel_cmd_s  = bus.cmd;
        sel_cin_s  = bus.cin;
        sel_a_s    = bus.opa;
        sel_b_s    = bus.opb;
        need_s     = need_ops(bus.mode, bus.cmd);
        prod_s     = mul_x_q * mul_y_q;

        if (bus.ce) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.inp_valid == 2'b00) begin
                        out_d     = '0;
                        out_d.err = 1'b1;
                    end else if (!cmd_ok(bus.mode, bus.cmd)) begin
                        out_d     = '0;
                        out_d.err = 1'b1;
                    end else if ((need_s & ~bus.inp_valid) == 2'b00) begin
                        go_s = 1'b1;
                    end else begin
                        opa_d     = bus.opa;
                        opb_d     = bus.opb;
                        cmd_d     = bus.cmd;
                        mode_d    = bus.mode;
                        cin_d     = bus.cin;
                        missing_d = need_s & ~bus.inp_valid;
                        timer_d   = '0;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    sel_mode_s = mode_q;
                    sel_cmd_s  = cmd_q;
                    sel_cin_s  = cin_q;
                    sel_a_s    = missing_q[0] ? bus.opa : opa_q;
                    sel_b_s    = missing_q[1] ? bus.opb : opb_q;
                    if ((missing_q & ~bus.inp_valid) == 2'b00) begin
                        go_s = 1'b1;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        out_d     = '0;
                        out_d.err = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                S_MUL: begin
                    out_d     = '0;
                    out_d.res = prod_s[N+1:0];
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // Multiplies split into a factor stage and a product stage
            if (go_s) begin
                if (is_mul(sel_mode_s, sel_cmd_s)) begin
                    if (sel_cmd_s == 4'd9) begin
                        mul_x_d = {1'b0, sel_a_s} + {{N{1'b0}}, 1'b1};
                        mul_y_d = {1'b0, sel_b_s} + {{N{1'b0}}, 1'b1};
                    end else begin
                        mul_x_d = {sel_a_s, 1'b0};
                        mul_y_d = {1'b0, sel_b_s};
                    end
                    state_d = S_MUL;
                end else begin
                    out_d   = exec_op(sel_mode_s, sel_cmd_s, sel_a_s, sel_b_s, sel_cin_s);
                    state_d = S_IDLE;
                end
            end else begin
                go_s = 1'b0;
            end
        end else begin
            go_s = 1'b0;
        end
    end

    // State, holding registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            missing_q <= 2'b00;
            opa_q     <= '0;
            opb_q     <= '0;
            cmd_q     <= '0;
            mode_q    <= 1'b0;
            cin_q     <= 1'b0;
            mul_x_q   <= '0;
            mul_y_q   <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            missing_q <= missing_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            cmd_q     <= cmd_d;
            mode_q    <= mode_d;
            cin_q     <= cin_d;
            mul_x_q   <= mul_x_d;
            mul_y_q   <= mul_y_d;
            out_q     <= out_d;
        end
    end

    assign bus.res   = out_q.res;
    assign bus.cout  = out_q.cout;
    assign bus.oflow = out_q.oflow;
    assign bus.g     = out_q.g;
    assign bus.l     = out_q.l;
    assign bus.e     = out_q.e;
    assign bus.err   = out_q.err;
endmodule

// File: tb/tb_alu_core_seq.sv
// Directed self-checking bench for alu_core_seq (default build, signed ops disabled).
module tb_alu_core_seq;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_core_seq_if #(.N(8), .M(4)) bus_if ();

    alu_core_seq #(.N(8), .M(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [5:0] flg;
    assign flg = {bus_if.cout, bus_if.oflow, bus_if.g, bus_if.l, bus_if.e, bus_if.err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus_if.ce        = 1'b0;
        bus_if.inp_valid = 2'b00;
    endtask

    // one enabled cycle of stimulus, then the bus goes quiet
    task automatic issue(input logic md, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input logic [1:0] v);
        bus_if.ce        = 1'b1;
        bus_if.mode      = md;
        bus_if.cmd       = c;
        bus_if.opa       = a;
        bus_if.opb       = b;
        bus_if.cin       = ci;
        bus_if.inp_valid = v;
        tick();
        idle_in();
    endtask

    task automatic run_enabled(input int n);
        bus_if.ce        = 1'b1;
        bus_if.inp_valid = 2'b00;
        for (int i = 0; i < n; i++) tick();
        idle_in();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_in();
        bus_if.mode = 1'b0;
        bus_if.cmd  = 4'd0;
        bus_if.opa  = 8'h00;
        bus_if.opb  = 8'h00;
        bus_if.cin  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("reset_res", {22'd0, bus_if.res}, 32'd0);
        check_eq("reset_flags", {26'd0, flg}, 32'd0);

        issue(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11);
        check_eq("add_res", {22'd0, bus_if.res}, 32'h100);
        check_eq("add_flags", {26'd0, flg}, 32'b100000);

        // split operands, with cmd changed while waiting
        issue(1'b1, 4'd0, 8'd5, 8'd0, 1'b0, 2'b01);
        check_eq("split_hold", {22'd0, bus_if.res}, 32'h100);
        bus_if.cmd = 4'd1;
        run_enabled(2);
        issue(1'b1, 4'd1, 8'd0, 8'd3, 1'b0, 2'b10);
        check_eq("split_res", {22'd0, bus_if.res}, 32'd8);
        check_eq("split_flags", {26'd0, flg}, 32'd0);

        issue(1'b1, 4'd0, 8'd5, 8'd0, 1'b0, 2'b01);
        run_enabled(15);
        check_eq("timeout_early", {26'd0, flg}, 32'd0);
        run_enabled(1);
        check_eq("timeout_err", {26'd0, flg}, 32'b000001);
        check_eq("timeout_res", {22'd0, bus_if.res}, 32'd0);

        issue(1'b1, 4'd8, 8'd3, 8'd9, 1'b0, 2'b11);
        check_eq("cmp_flags", {26'd0, flg}, 32'b000100);
        check_eq("cmp_res", {22'd0, bus_if.res}, 32'd0);

        issue(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
        check_eq("mulinc_stage1", {26'd0, flg}, 32'b000100);
        run_enabled(1);
        check_eq("mulinc_res", {22'd0, bus_if.res}, 32'd20);
        check_eq("mulinc_flags", {26'd0, flg}, 32'd0);

        issue(1'b1, 4'd10, 8'd3, 8'd4, 1'b0, 2'b11);
        run_enabled(1);
        check_eq("mulshift_res", {22'd0, bus_if.res}, 32'd24);

        issue(1'b1, 4'd1, 8'd2, 8'd5, 1'b0, 2'b11);
        check_eq("sub_res", {22'd0, bus_if.res}, 32'h1FD);
        check_eq("sub_flags", {26'd0, flg}, 32'b010000);
        issue(1'b1, 4'd5, 8'h00, 8'h00, 1'b0, 2'b01);
        check_eq("dec_wrap", {21'd0, bus_if.oflow, bus_if.res}, {21'd0, 1'b1, 10'h0FF});
        issue(1'b1, 4'd6, 8'h00, 8'hFF, 1'b0, 2'b10);
        check_eq("inc_wrap", {21'd0, bus_if.oflow, bus_if.res}, {21'd0, 1'b1, 10'h000});

        issue(1'b0, 4'd4, 8'hF0, 8'h3C, 1'b0, 2'b11);
        check_eq("xor_res", {22'd0, bus_if.res}, 32'hCC);
        issue(1'b0, 4'd9, 8'h81, 8'h00, 1'b0, 2'b01);
        check_eq("shl_res", {22'd0, bus_if.res}, 32'h02);
        issue(1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 2'b11);
        check_eq("rol_res", {22'd0, bus_if.res}, 32'h03);
        check_eq("rol_err", {31'd0, bus_if.err}, 32'd0);
        issue(1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 2'b11);
        check_eq("rol_bad_amt", {21'd0, bus_if.err, bus_if.res}, {21'd0, 1'b1, 10'h003});
        issue(1'b0, 4'd13, 8'h81, 8'h01, 1'b0, 2'b11);
        check_eq("ror_res", {21'd0, bus_if.err, bus_if.res}, {21'd0, 1'b0, 10'h0C0});

        issue(1'b1, 4'd14, 8'd1, 8'd1, 1'b0, 2'b11);
        check_eq("bad_cmd", {21'd0, bus_if.err, bus_if.res}, {21'd0, 1'b1, 10'h000});
        issue(1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
        check_eq("add_small", {21'd0, bus_if.err, bus_if.res}, {21'd0, 1'b0, 10'd2});
`ifndef ALU_SIGNED_EN
        issue(1'b1, 4'd11, 8'd1, 8'd1, 1'b0, 2'b11);
        check_eq("cmd11_invalid", {31'd0, bus_if.err}, 32'd1);
`endif
        issue(1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b00);
        check_eq("no_valid", {21'd0, bus_if.err, bus_if.res}, {21'd0, 1'b1, 10'h000});

        // timeout with ce low for 5 cycles mid-wait
        issue(1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 2'b11);
        issue(1'b1, 4'd0, 8'd0, 8'd7, 1'b0, 2'b10);
        run_enabled(5);
        for (int i = 0; i < 5; i++) tick();
        check_eq("ce_hold", {16'd0, bus_if.res, flg}, {16'd0, 10'd3, 6'd0});
        run_enabled(10);
        check_eq("ce_timer_frozen", {31'd0, bus_if.err}, 32'd0);
        run_enabled(1);
        check_eq("ce_timeout_err", {31'd0, bus_if.err}, 32'd1);

        // reset mid-wait aborts; next op starts from IDLE
        issue(1'b1, 4'd0, 8'd2, 8'd2, 1'b0, 2'b11);
        issue(1'b1, 4'd0, 8'd9, 8'd0, 1'b0, 2'b01);
        run_enabled(3);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_wait_res", {22'd0, bus_if.res}, 32'd0);
        check_eq("rst_wait_flags", {26'd0, flg}, 32'd0);
        issue(1'b1, 4'd0, 8'd9, 8'd1, 1'b0, 2'b11);
        check_eq("post_rst_add", {22'd0, bus_if.res}, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
